// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU shift sequencer and its downstream ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam int ALU_DATA_W    = 3;
    localparam int ALU_CNT_W     = 3;
    localparam int ALU_MAX_SHIFT = 2 * ALU_DATA_W;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_SHIFT = 2'b01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/shiftreg_ALU.sv
// Downstream 2*DATA_W shift-register ALU: first enabled shift cycle loads {A,B}<<1, later cycles shift left.
// Latency: one cycle per enabled clock; reset is synchronous and only takes effect while en=1.
// Backpressure: none; op values other than OP_SHIFT hold the current contents.
module shiftreg_ALU #(
    parameter int DATA_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            op,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    output logic [2*DATA_W-1:0]   Doutshift
);
    import alu_seq_pkg::*;

    logic [2*DATA_W-1:0] r_dout;
    logic                r_refresh;
    logic [2*DATA_W-1:0] w_load;

    assign w_load    = {A, B};
    assign Doutshift = r_dout;

    // Refresh flag selects load-then-shift on the first cycle after a clear
    always_ff @(posedge clk) begin
        if (en) begin
            if (!rst_n) begin
                r_dout    <= '0;
                r_refresh <= 1'b0;
            end else if (op == OP_SHIFT) begin
                if (!r_refresh) begin
                    r_dout    <= {w_load[2*DATA_W-2:0], 1'b0};
                    r_refresh <= 1'b1;
                end else begin
                    r_dout    <= {r_dout[2*DATA_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Command stage: takes {op,A,B,count}, clears the ALU, runs it for count shifts, returns Doutshift.
// Latency: result valid n+3 cycles after accept (n = count saturated to MAX_SHIFT).
// Backpressure: cmd_ready only in IDLE (no queuing); result held in DONE until res_ready.
module alu_shift_sequencer #(
    parameter int DATA_W    = 3,
    parameter int CNT_W     = 3,
    parameter int MAX_SHIFT = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_W-1:0]     cmd_a,
    input  logic [DATA_W-1:0]     cmd_b,
    input  logic [CNT_W-1:0]      cmd_cnt,
    output logic                  alu_en,
    output logic                  alu_rst_n,
    output logic [1:0]            alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic [2*DATA_W-1:0]   alu_dout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*DATA_W-1:0]   res_data,
    output logic                  busy
);
    import alu_seq_pkg::*;

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_SHIFT);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    state_t              r_state;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_res_valid;
    logic [2*DATA_W-1:0] r_res_data;
    logic [CNT_W-1:0]    w_cnt_sat;

    // Counts beyond the word width would shift everything out; clamp them
    always_comb begin
        w_cnt_sat = (cmd_cnt > LP_MAX) ? LP_MAX : cmd_cnt;
    end

    // Sequencer FSM with inline shift down-counter and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_NOP;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_a     <= cmd_a;
                        r_b     <= cmd_b;
                        r_cnt   <= w_cnt_sat;
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_state <= (r_cnt != '0) ? RUN : CAPTURE;
                end
                RUN: begin
                    r_cnt <= r_cnt - LP_ONE;
                    if (r_cnt == LP_ONE) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_res_data  <= alu_dout;
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ALU drive decoded from state; reset forces an ALU clear alongside our own
    always_comb begin
        alu_en    = 1'b0;
        alu_rst_n = 1'b1;
        alu_op    = OP_NOP;
        if (!rst_n) begin
            alu_en    = 1'b1;
            alu_rst_n = 1'b0;
        end else if (r_state == CLEAR) begin
            alu_en    = 1'b1;
            alu_rst_n = 1'b0;
        end else if (r_state == RUN) begin
            alu_en    = 1'b1;
            alu_op    = r_op;
        end
    end

    assign cmd_ready = rst_n && (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
module tb_alu_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_a;
    logic [2:0] cmd_b;
    logic [2:0] cmd_cnt;
    logic       alu_en;
    logic       alu_rst_n;
    logic [1:0] alu_op;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [5:0] alu_dout;
    logic       res_valid;
    logic       res_ready;
    logic [5:0] res_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    alu_shift_sequencer #(.DATA_W(3), .CNT_W(3), .MAX_SHIFT(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cnt(cmd_cnt),
        .alu_en(alu_en), .alu_rst_n(alu_rst_n), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_dout(alu_dout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    shiftreg_ALU #(.DATA_W(3)) alu (
        .clk(clk), .rst_n(alu_rst_n), .en(alu_en), .op(alu_op),
        .A(alu_a), .B(alu_b), .Doutshift(alu_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, return the result and edges from accept (inclusive) to res_valid seen
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] cnt, input logic hold_rdy,
                          output logic [5:0] data, output int lat);
        int w;
        w = 0;
        while (!cmd_ready && w < 20) begin
            step();
            w++;
        end
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cnt = cnt;
        cmd_valid = 1'b1;
        if (hold_rdy) res_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 40) begin
            step();
            lat++;
        end
        if (!res_valid) lat = -1;
        data = res_data;
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
        checks++; if (res_data !== 6'h00) begin errors++; $display("FAIL reset_res_data got %h want 00", res_data); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %0b want 0", cmd_ready); end
        checks++; if (alu_rst_n !== 1'b0 || alu_en !== 1'b1 || alu_op !== 2'b00) begin
            errors++; $display("FAIL reset_alu_drive got rst_n=%0b en=%0b op=%b want 0/1/00", alu_rst_n, alu_en, alu_op); end
        checks++; if (alu_dout !== 6'h00) begin errors++; $display("FAIL reset_alu_cleared got %h want 00", alu_dout); end
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release got cmd_ready=%0b busy=%0b want 1/0", cmd_ready, busy); end
        checks++; if (alu_en !== 1'b0 || alu_rst_n !== 1'b1) begin
            errors++; $display("FAIL idle_alu_drive got en=%0b rst_n=%0b want 0/1", alu_en, alu_rst_n); end
    endtask

    task automatic test_basic_shift();
        int lat;
        cmd_op = 2'b01; cmd_a = 3'b101; cmd_b = 3'b011; cmd_cnt = 3'd1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        lat = 1;
        // CLEAR
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || alu_en !== 1'b1 || alu_rst_n !== 1'b0) begin
            errors++; $display("FAIL basic_clear got busy=%0b rdy=%0b en=%0b rst_n=%0b want 1/0/1/0", busy, cmd_ready, alu_en, alu_rst_n); end
        step(); lat++;
        // RUN
        checks++; if (alu_en !== 1'b1 || alu_rst_n !== 1'b1 || alu_op !== 2'b01 || alu_a !== 3'b101 || alu_b !== 3'b011) begin
            errors++; $display("FAIL basic_run got en=%0b rst_n=%0b op=%b a=%b b=%b want 1/1/01/101/011", alu_en, alu_rst_n, alu_op, alu_a, alu_b); end
        while (!res_valid && lat < 40) begin step(); lat++; end
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
        checks++; if (res_data !== 6'h16) begin errors++; $display("FAIL basic_data got %h want 16", res_data); end
        release_res();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_release got valid=%0b busy=%0b want 0/0", res_valid, busy); end
    endtask

    task automatic test_multi_shift();
        logic [5:0] d;
        int lat;
        do_cmd(2'b01, 3'b101, 3'b011, 3'd3, 1'b0, d, lat);
        checks++; if (d !== 6'h18) begin errors++; $display("FAIL multi3_data got %h want 18", d); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL multi3_latency got %0d want 6", lat); end
        release_res();
        // res_ready held high throughout this run: no effect until DONE
        do_cmd(2'b01, 3'b111, 3'b111, 3'd2, 1'b1, d, lat);
        checks++; if (d !== 6'h3C) begin errors++; $display("FAIL multi2_data got %h want 3c", d); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL multi2_latency got %0d want 5", lat); end
        release_res();
    endtask

    task automatic test_edges();
        logic [5:0] d;
        int lat;
        do_cmd(2'b01, 3'b101, 3'b011, 3'd0, 1'b0, d, lat);
        checks++; if (d !== 6'h00) begin errors++; $display("FAIL cnt0_data got %h want 00", d); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL cnt0_latency got %0d want 3", lat); end
        release_res();
        do_cmd(2'b01, 3'b101, 3'b011, 3'd7, 1'b0, d, lat);
        checks++; if (d !== 6'h00) begin errors++; $display("FAIL cnt7_data got %h want 00", d); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL cnt7_latency got %0d want 9", lat); end
        release_res();
        do_cmd(2'b01, 3'b001, 3'b101, 3'd5, 1'b0, d, lat);
        checks++; if (d !== 6'h20) begin errors++; $display("FAIL cnt5_data got %h want 20", d); end
        release_res();
        do_cmd(2'b10, 3'b101, 3'b011, 3'd2, 1'b0, d, lat);
        checks++; if (d !== 6'h00) begin errors++; $display("FAIL op10_data got %h want 00", d); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL op10_latency got %0d want 5", lat); end
        release_res();
    endtask

    task automatic test_backpressure();
        logic [5:0] d;
        int lat;
        do_cmd(2'b01, 3'b101, 3'b011, 3'd2, 1'b0, d, lat);
        checks++; if (d !== 6'h2C) begin errors++; $display("FAIL bp_data got %h want 2c", d); end
        cmd_op = 2'b01; cmd_a = 3'b111; cmd_b = 3'b000; cmd_cnt = 3'd1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (res_valid !== 1'b1 || res_data !== 6'h2C || cmd_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cycle %0d got valid=%0b data=%h rdy=%0b want 1/2c/0", i, res_valid, res_data, cmd_ready); end
        end
        res_ready = 1'b1;
        cmd_valid = 1'b0;
        step();
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid=%0b busy=%0b rdy=%0b want 0/0/1", res_valid, busy, cmd_ready); end
    endtask

    task automatic test_mid_reset();
        logic [5:0] d;
        int lat;
        int seen;
        cmd_op = 2'b01; cmd_a = 3'b101; cmd_b = 3'b011; cmd_cnt = 3'd5;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        checks++; if (alu_op !== 2'b01 || busy !== 1'b1) begin
            errors++; $display("FAIL midrst_in_run got op=%b busy=%0b want 01/1", alu_op, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (alu_en !== 1'b1 || alu_rst_n !== 1'b0) begin
            errors++; $display("FAIL midrst_alu_drive got en=%0b rst_n=%0b want 1/0", alu_en, alu_rst_n); end
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (res_valid !== 1'b0 || busy !== 1'b0) seen++;
            step();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_result got %0d active cycles want 0", seen); end
        checks++; if (alu_dout !== 6'h00) begin errors++; $display("FAIL midrst_alu_cleared got %h want 00", alu_dout); end
        do_cmd(2'b01, 3'b001, 3'b000, 3'd1, 1'b0, d, lat);
        checks++; if (d !== 6'h10) begin errors++; $display("FAIL midrst_next_data got %h want 10", d); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_next_latency got %0d want 4", lat); end
        release_res();
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0; cmd_cnt = '0;
        res_ready = 1'b0;
        test_reset();
        test_basic_shift();
        test_multi_shift();
        test_edges();
        test_backpressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
